compute_cluster_sequencer: RTL and testbench

Control FSM that drives a Compute_Cluster through one layer pass. It loads the filter memories of all compute units in order and loads the first IFM chunk, then runs chunks back to back. While the cluster computes chunk k from one IFM buffer, chunk k+1 is loaded into the other buffer. Sits between the layer-level DMA/source streams and the cluster's write, select and chunk-control pins.

---
 rtl/compute_cluster_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_compute_cluster_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_cluster_sequencer.sv
// Pass sequencer for a compute cluster: filter load, first IFM load, then
// back-to-back chunks with the next IFM chunk prefetched into the idle buffer.
module compute_cluster_sequencer #(
    parameter int MEM_SIZE         = 128,
    parameter int BUS_SIZE         = 8,
    parameter int OUTPUT_BUF_NUM   = 32,
    parameter int COMPUTE_UNIT_NUM = 32,
    parameter int CHUNK_W          = 16,
    localparam int BEATS = MEM_SIZE / BUS_SIZE,
    localparam int CNT_W = $clog2(BEATS),
    localparam int ORD_W = $clog2(COMPUTE_UNIT_NUM),
    localparam int BUF_W = $clog2(OUTPUT_BUF_NUM)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start_i,
    input  logic [CHUNK_W-1:0] chunk_num_i,
    input  logic               filt_src_valid_i,
    output logic               filt_src_ready_o,
    input  logic               ifm_src_valid_i,
    output logic               ifm_src_ready_o,
    output logic               filter_wr_valid_o,
    output logic [CNT_W-1:0]   filter_wr_count_o,
    output logic [ORD_W-1:0]   filter_wr_order_sel_o,
    output logic               filter_wr_sel_o,
    output logic               filter_rd_sel_o,
    output logic               ifm_wr_valid_o,
    output logic [CNT_W-1:0]   ifm_wr_count_o,
    output logic               ifm_wr_sel_o,
    output logic               ifm_rd_sel_o,
    output logic               init_o,
    output logic               chunk_start_o,
    input  logic               chunk_end_i,
    output logic [BUF_W-1:0]   acc_buf_sel_o,
    output logic [BUF_W-1:0]   out_buf_sel_o,
    output logic               busy_o,
    output logic               done_o
);

    // state     | meaning
    // IDLE      | waiting for start_i
    // LOAD_FILT | filter beats streamed into each compute unit in order
    // LOAD_IFM0 | first IFM chunk streamed into buffer 0
    // START     | one-cycle chunk start pulse
    // RUN       | cluster computing; next chunk prefetched into idle buffer
    // WAIT_PF   | chunk finished before its successor was fully prefetched
    // DONE      | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FILT,
        S_LOAD_IFM0,
        S_START,
        S_RUN,
        S_WAIT_PF,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CHUNK_W-1:0] chunk_num;
    logic [CHUNK_W-1:0] loaded;
    logic [CHUNK_W-1:0] ended;
    logic [ORD_W-1:0]   order_sel;
    logic [CNT_W-1:0]   filt_cnt;
    logic [CNT_W-1:0]   ifm_cnt;
    logic [BUF_W-1:0]   buf_sel;
    logic               pf_full;
    logic               wr_sel;
    logic               rd_sel;

    logic filt_en, ifm_en, pf_en;
    logic filt_acc, ifm_acc, filt_last, ifm_last;
    logic end_run, last_chunk;
    logic do_clear, do_swap;

    assign pf_en   = (loaded < chunk_num) && !pf_full;
    assign filt_en = (state == S_LOAD_FILT);
    assign ifm_en  = (state == S_LOAD_IFM0) ||
                     (((state == S_RUN) || (state == S_WAIT_PF)) && pf_en);

    assign filt_acc  = filt_src_valid_i & filt_en;
    assign ifm_acc   = ifm_src_valid_i & ifm_en;
    assign filt_last = filt_acc && (filt_cnt == CNT_W'(BEATS - 1));
    assign ifm_last  = ifm_acc && (ifm_cnt == CNT_W'(BEATS - 1));

    assign end_run    = chunk_end_i && (state == S_RUN);
    assign last_chunk = ((ended + 1'b1) == chunk_num);

    always_comb begin
        state_nxt     = state;
        init_o        = 1'b0;
        chunk_start_o = 1'b0;
        done_o        = 1'b0;
        do_clear      = 1'b0;
        do_swap       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (chunk_num_i != '0) begin
                        do_clear  = 1'b1;
                        state_nxt = S_LOAD_FILT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_LOAD_FILT: begin
                init_o = 1'b1;
                if (filt_last && (order_sel == ORD_W'(COMPUTE_UNIT_NUM - 1)))
                    state_nxt = S_LOAD_IFM0;
            end
            S_LOAD_IFM0: begin
                init_o = 1'b1;
                if (ifm_last)
                    state_nxt = S_START;
            end
            S_START: begin
                chunk_start_o = 1'b1;
                state_nxt     = S_RUN;
            end
            S_RUN: begin
                if (chunk_end_i) begin
                    if (last_chunk) begin
                        state_nxt = S_DONE;
                    end else if (pf_full || ifm_last) begin
                        // a prefetch finishing on the same cycle counts as full
                        do_swap   = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_WAIT_PF;
                    end
                end
            end
            S_WAIT_PF: begin
                if (ifm_last) begin
                    do_swap   = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            chunk_num <= '0;
            loaded    <= '0;
            ended     <= '0;
            order_sel <= '0;
            filt_cnt  <= '0;
            ifm_cnt   <= '0;
            buf_sel   <= '0;
            pf_full   <= 1'b0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (do_clear) begin
                chunk_num <= chunk_num_i;
                loaded    <= '0;
                ended     <= '0;
                order_sel <= '0;
                filt_cnt  <= '0;
                ifm_cnt   <= '0;
                buf_sel   <= '0;
                pf_full   <= 1'b0;
                wr_sel    <= 1'b0;
                rd_sel    <= 1'b0;
            end else begin
                if (filt_acc)
                    filt_cnt <= filt_last ? '0 : filt_cnt + 1'b1;
                if (filt_last)
                    order_sel <= (order_sel == ORD_W'(COMPUTE_UNIT_NUM - 1)) ?
                                 '0 : order_sel + 1'b1;
                if (ifm_acc)
                    ifm_cnt <= ifm_last ? '0 : ifm_cnt + 1'b1;
                if (ifm_last) begin
                    loaded <= loaded + 1'b1;
                    if (state == S_LOAD_IFM0)
                        wr_sel <= ~wr_sel;
                    else
                        pf_full <= 1'b1;
                end
                if (end_run)
                    ended <= ended + 1'b1;
                // swap is last so it overrides a same-cycle pf_full set
                if (do_swap) begin
                    rd_sel  <= ~rd_sel;
                    wr_sel  <= ~wr_sel;
                    buf_sel <= buf_sel + 1'b1;
                    pf_full <= 1'b0;
                end
            end
        end
    end

    assign filt_src_ready_o      = filt_acc;
    assign filter_wr_valid_o     = filt_acc;
    assign filter_wr_count_o     = filt_cnt;
    assign filter_wr_order_sel_o = order_sel;
    assign filter_wr_sel_o       = 1'b0;
    assign filter_rd_sel_o       = 1'b0;
    assign ifm_src_ready_o       = ifm_acc;
    assign ifm_wr_valid_o        = ifm_acc;
    assign ifm_wr_count_o        = ifm_cnt;
    assign ifm_wr_sel_o          = wr_sel;
    assign ifm_rd_sel_o          = rd_sel;
    assign acc_buf_sel_o         = buf_sel;
    assign out_buf_sel_o         = buf_sel;
    assign busy_o                = (state != S_IDLE);

endmodule

// File: tb/tb_compute_cluster_sequencer.sv
// Bench for compute_cluster_sequencer: a pass-level model (beat and chunk
// counts) checked against every output each cycle, plus literal pass checks.
module tb_compute_cluster_sequencer;

    localparam int BEATS      = 16;
    localparam int CU         = 32;
    localparam int OBN        = 32;
    localparam int CW         = 16;
    localparam int CNT_W      = 4;
    localparam int ORD_W      = 5;
    localparam int BUF_W      = 5;
    localparam int FILT_TOTAL = CU * BEATS;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             start_i;
    logic [CW-1:0]    chunk_num_i;
    logic             filt_src_valid_i, filt_src_ready_o;
    logic             ifm_src_valid_i, ifm_src_ready_o;
    logic             filter_wr_valid_o;
    logic [CNT_W-1:0] filter_wr_count_o;
    logic [ORD_W-1:0] filter_wr_order_sel_o;
    logic             filter_wr_sel_o, filter_rd_sel_o;
    logic             ifm_wr_valid_o;
    logic [CNT_W-1:0] ifm_wr_count_o;
    logic             ifm_wr_sel_o, ifm_rd_sel_o;
    logic             init_o, chunk_start_o, chunk_end_i;
    logic [BUF_W-1:0] acc_buf_sel_o, out_buf_sel_o;
    logic             busy_o, done_o;

    compute_cluster_sequencer dut (
        .CLK(CLK), .RESET(RESET), .start_i(start_i), .chunk_num_i(chunk_num_i),
        .filt_src_valid_i(filt_src_valid_i), .filt_src_ready_o(filt_src_ready_o),
        .ifm_src_valid_i(ifm_src_valid_i), .ifm_src_ready_o(ifm_src_ready_o),
        .filter_wr_valid_o(filter_wr_valid_o), .filter_wr_count_o(filter_wr_count_o),
        .filter_wr_order_sel_o(filter_wr_order_sel_o),
        .filter_wr_sel_o(filter_wr_sel_o), .filter_rd_sel_o(filter_rd_sel_o),
        .ifm_wr_valid_o(ifm_wr_valid_o), .ifm_wr_count_o(ifm_wr_count_o),
        .ifm_wr_sel_o(ifm_wr_sel_o), .ifm_rd_sel_o(ifm_rd_sel_o),
        .init_o(init_o), .chunk_start_o(chunk_start_o), .chunk_end_i(chunk_end_i),
        .acc_buf_sel_o(acc_buf_sel_o), .out_buf_sel_o(out_buf_sel_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    initial forever #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge CLK) cyc++;

    logic [34:0] act_v;
    assign act_v = {filt_src_ready_o, ifm_src_ready_o, filter_wr_valid_o,
                    filter_wr_count_o, filter_wr_order_sel_o, filter_wr_sel_o,
                    filter_rd_sel_o, ifm_wr_valid_o, ifm_wr_count_o, ifm_wr_sel_o,
                    ifm_rd_sel_o, init_o, chunk_start_o, acc_buf_sel_o,
                    out_buf_sel_o, busy_o, done_o};

    // pass model: progress is tracked only as beat totals and chunk counts
    bit m_live = 0;
    bit m_busy, m_done, m_start;
    int m_n, m_fb, m_ib, m_started, m_ended;

    function automatic bit m_filt_en();
        return m_busy && !m_done && (m_fb < FILT_TOTAL);
    endfunction

    // buffered chunks = m_ib/BEATS; prefetch only when nothing is waiting unstarted
    function automatic bit m_ifm_en();
        int ld;
        ld = m_ib / BEATS;
        return m_busy && !m_done && (m_fb == FILT_TOTAL) &&
               ((m_ib < BEATS) ||
                (!m_start && (m_started >= 1) && (ld == m_started) && (ld < m_n)));
    endfunction

    function automatic logic [34:0] model_out();
        bit fv, iv, init;
        logic [BUF_W-1:0] bs;
        fv   = m_filt_en() & filt_src_valid_i;
        iv   = m_ifm_en() & ifm_src_valid_i;
        init = m_busy && !m_done && (m_ib < BEATS);
        bs   = BUF_W'((m_started > 0) ? (m_started - 1) % OBN : 0);
        return {fv, iv, fv, CNT_W'(m_fb % BEATS), ORD_W'((m_fb / BEATS) % CU),
                1'b0, 1'b0, iv, CNT_W'(m_ib % BEATS), 1'(m_started % 2),
                1'((m_started > 0) ? (m_started - 1) % 2 : 0), init, m_start,
                bs, bs, m_busy, m_done};
    endfunction

    always @(posedge CLK) begin
        bit fen, ien, was_start;
        int st0, en0, ld;
        fen = m_filt_en();
        ien = m_ifm_en();
        if (RESET) begin
            m_live = 1; m_busy = 0; m_done = 0; m_start = 0;
            m_n = 0; m_fb = 0; m_ib = 0; m_started = 0; m_ended = 0;
        end else if (m_live) begin
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (start_i) begin
                    m_busy = 1;
                    if (chunk_num_i == '0) m_done = 1;
                    else begin
                        m_n = int'(chunk_num_i);
                        m_fb = 0; m_ib = 0; m_started = 0; m_ended = 0;
                    end
                end
            end else begin
                was_start = m_start;
                st0 = m_started;
                en0 = m_ended;
                m_start = 0;
                if (fen && filt_src_valid_i) m_fb++;
                if (ien && ifm_src_valid_i) m_ib++;
                ld = m_ib / BEATS;
                if (st0 == 0) begin
                    if (ld == 1) begin m_start = 1; m_started = 1; end
                end else if (!was_start && st0 > en0) begin
                    if (chunk_end_i) begin
                        m_ended++;
                        if (m_ended == m_n) m_done = 1;
                        else if (ld > st0) begin m_start = 1; m_started++; end
                    end
                end else if (!was_start && ld > st0) begin
                    m_start = 1;
                    m_started++;
                end
            end
        end
    end

    // pass log and cluster stand-in
    int lat = 40;
    bit slow_ifm = 0;
    bit force_end = 0;
    int end_due = -1;
    int n_fb, n_ib, n_starts, n_done, empty_starts, wait_starts, late_starts;
    int last_ifm_cyc, last_end_cyc, done_cyc, st_cyc;
    int acc_log[64];
    int rd_log[64];

    always @(negedge CLK) begin
        logic [34:0] exp_v;
        exp_v = model_out();
        if (m_live) begin
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                if (fails <= 20)
                    $display("FAIL cycle_outputs cyc=%0d got %h expected %h", cyc, act_v, exp_v);
            end
        end
        if (filter_wr_valid_o) n_fb++;
        if (ifm_wr_valid_o) begin n_ib++; last_ifm_cyc = cyc; end
        if (chunk_end_i && cyc == end_due) last_end_cyc = cyc;
        if (chunk_start_o && n_starts < 64) begin
            acc_log[n_starts] = int'(acc_buf_sel_o);
            rd_log[n_starts]  = int'(ifm_rd_sel_o);
            if (n_ib < BEATS * (n_starts + 1)) empty_starts++;
            if (n_starts > 0 && cyc - last_end_cyc > 1) begin
                wait_starts++;
                if (last_ifm_cyc != cyc - 1) late_starts++;
            end
            n_starts++;
            end_due = cyc + lat;
        end
        if (done_o) begin n_done++; done_cyc = cyc; end
    end

    initial begin
        filt_src_valid_i = 1'b0;
        ifm_src_valid_i  = 1'b0;
        chunk_end_i      = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            filt_src_valid_i = 1'b1;
            ifm_src_valid_i  = slow_ifm ? (cyc % 4 == 0) : 1'b1;
            chunk_end_i      = force_end || (cyc == end_due);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        n_fb = 0; n_ib = 0; n_starts = 0; n_done = 0;
        empty_starts = 0; wait_starts = 0; late_starts = 0;
        last_ifm_cyc = -10; last_end_cyc = -10; done_cyc = -1; end_due = -1;
    endtask

    task automatic run_pass(input int n, input int l, input bit slow, input bit inject);
        bit injected;
        int k;
        clear_log();
        lat = l;
        slow_ifm = slow;
        tick();
        start_i = 1'b1;
        chunk_num_i = CW'(n);
        st_cyc = cyc;
        tick();
        start_i = 1'b0;
        chunk_num_i = '0;
        k = 0;
        injected = 0;
        while (n_done == 0 && k < 4000) begin
            tick();
            k++;
            force_end = inject && (k == 20);
            if (inject && !injected && n_starts == 2) begin
                start_i = 1'b1;
                chunk_num_i = CW'(9);
                injected = 1;
            end else begin
                start_i = 1'b0;
            end
        end
        force_end = 0;
        start_i = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        RESET = 1'b1;
        start_i = 1'b0;
        chunk_num_i = '0;
        clear_log();
        repeat (10) tick();
        @(negedge CLK);
        chk("reset_outputs", act_v, 0);
        tick();
        RESET = 1'b0;

        run_pass(4, 40, 0, 0);
        chk("full_filt_beats", n_fb, 512);
        chk("full_ifm_beats", n_ib, 64);
        chk("full_starts", n_starts, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full_acc_sel%0d", i), acc_log[i], i);
            chk($sformatf("full_rd_sel%0d", i), rd_log[i], i % 2);
        end
        chk("full_done_count", n_done, 1);
        chk("full_empty_starts", empty_starts, 0);

        run_pass(3, 10, 1, 0);
        chk("slow_wait_starts", wait_starts, 2);
        chk("slow_late_starts", late_starts, 0);
        chk("slow_empty_starts", empty_starts, 0);
        chk("slow_ifm_beats", n_ib, 48);
        chk("slow_done_count", n_done, 1);

        run_pass(34, 20, 0, 0);
        chk("wrap_starts", n_starts, 34);
        chk("wrap_acc30", acc_log[30], 30);
        chk("wrap_acc31", acc_log[31], 31);
        chk("wrap_acc32", acc_log[32], 0);
        chk("wrap_acc33", acc_log[33], 1);
        chk("wrap_done_after_end", done_cyc - last_end_cyc, 1);
        chk("wrap_done_count", n_done, 1);

        run_pass(0, 10, 0, 0);
        chk("zero_done_latency", done_cyc - st_cyc, 1);
        chk("zero_filt_beats", n_fb, 0);
        chk("zero_ifm_beats", n_ib, 0);
        chk("zero_done_count", n_done, 1);

        run_pass(3, 30, 0, 1);
        chk("edge_starts", n_starts, 3);
        chk("edge_filt_beats", n_fb, 512);
        chk("edge_done_count", n_done, 1);

        clear_log();
        lat = 25;
        tick();
        start_i = 1'b1;
        chunk_num_i = CW'(4);
        tick();
        start_i = 1'b0;
        k = 0;
        while (n_starts < 2 && k < 4000) begin tick(); k++; end
        repeat (3) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort_outputs", act_v, 0);
        repeat (40) tick();
        chk("abort_no_done", n_done, 0);

        run_pass(2, 25, 0, 0);
        chk("after_abort_starts", n_starts, 2);
        chk("after_abort_filt_beats", n_fb, 512);
        chk("after_abort_done_count", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
